// File: rtl/any1_tlb_walker_pkg.sv
// any1_pkg: shared types and constants for the any1 TLB page-table walker.
package any1_pkg;

  // Walker states, kept as plain encoded constants for the legacy netlist.
  typedef logic [2:0] walk_state_t;
  localparam walk_state_t ST_IDLE    = 3'd0;
  localparam walk_state_t ST_L1_REQ  = 3'd1;
  localparam walk_state_t ST_L1_WAIT = 3'd2;
  localparam walk_state_t ST_L2_REQ  = 3'd3;
  localparam walk_state_t ST_L2_WAIT = 3'd4;
  localparam walk_state_t ST_WRITE   = 3'd5;
  localparam walk_state_t ST_DONE    = 3'd6;
  localparam walk_state_t ST_FAULT   = 3'd7;

  // PTE bit positions (low 32-bit word of a 64-bit PTE).
  localparam int unsigned PTE_V       = 0;
  localparam int unsigned PTE_R       = 1;
  localparam int unsigned PTE_W       = 2;
  localparam int unsigned PTE_X       = 3;
  localparam int unsigned PTE_U       = 4;
  localparam int unsigned PTE_G       = 5;
  localparam int unsigned PTE_A       = 6;
  localparam int unsigned PTE_D       = 7;
  localparam int unsigned PTE_RSW_LSB = 8;
  localparam int unsigned PTE_RSW_MSB = 13;
  localparam int unsigned PTE_PPN_LSB = 14;
  localparam int unsigned PTE_PPN_MSB = 31;

  // Fault causes.
  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_ROOT = 2'd1;
  localparam logic [1:0] FC_LEAF = 2'd2;
  localparam logic [1:0] FC_BUS  = 2'd3;

  // TLB entry as consumed by any1_TLB tlbdat_i.
  typedef struct packed {
    logic        v;
    logic        g;
    logic        d;
    logic        a;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic [7:0]  asid;
    logic [7:0]  vpn;
    logic [5:0]  rsw;
    logic [15:0] rsvd;
    logic [17:0] ppn;
  } tlbe_t;

  // Reformat a leaf PTE into a TLB entry tagged with vpn and asid.
  function automatic tlbe_t pte_to_tlbe(input logic [31:0] pte,
                                        input logic [7:0]  vpn,
                                        input logic [7:0]  asid);
    tlbe_t e;
    e.v    = pte[PTE_V];
    e.g    = pte[PTE_G];
    e.d    = pte[PTE_D];
    e.a    = pte[PTE_A];
    e.u    = pte[PTE_U];
    e.x    = pte[PTE_X];
    e.w    = pte[PTE_W];
    e.r    = pte[PTE_R];
    e.asid = asid;
    e.vpn  = vpn;
    e.rsw  = pte[PTE_RSW_MSB:PTE_RSW_LSB];
    e.rsvd = '0;
    e.ppn  = pte[PTE_PPN_MSB:PTE_PPN_LSB];
    return e;
  endfunction

endpackage

// File: rtl/any1_tlb_walker.sv
// any1_tlb_walker: two-level hardware page-table walker and TLB write-port arbiter.
module any1_tlb_walker
  import any1_pkg::*;
#(
  parameter int unsigned AWID    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            miss_i,
  input  logic [AWID-1:0] miss_adr_i,
  input  logic [7:0]      asid_i,
  input  logic [AWID-1:0] ptbr_i,
  input  logic            sw_wr_i,
  input  logic [15:0]     sw_adr_i,
  input  logic [63:0]     sw_dat_i,
  output logic            sw_busy_o,
  output logic            cyc_o,
  output logic            stb_o,
  output logic [AWID-1:0] adr_o,
  input  logic            ack_i,
  input  logic            err_i,
  input  logic [63:0]     dat_i,
  output logic            wrtlb_o,
  output logic [15:0]     tlbadr_o,
  output logic [63:0]     tlbdat_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            fault_o,
  output logic [1:0]      fault_cause_o
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  walk_state_t      state;
  logic [AWID-1:14] va_q;
  logic [7:0]       asid_q;
  logic [AWID-1:11] root_q;
  logic [31:0]      pte_q;
  logic [CW-1:0]    cnt_q;
  logic             cyc_q;
  logic [AWID-1:0]  adr_q;
  logic [1:0]       cause_q;
  tlbe_t            tlbe;
  logic             unused_bits;

  // Walk sequencer; bus strobes are registered so cyc_o drops for one cycle between reads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      va_q    <= '0;
      asid_q  <= '0;
      root_q  <= '0;
      pte_q   <= '0;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      adr_q   <= '0;
      cause_q <= FC_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (miss_i) begin
            va_q    <= miss_adr_i[AWID-1:14];
            asid_q  <= asid_i;
            cause_q <= FC_NONE;
            state   <= ST_L1_REQ;
          end
        end
        ST_L1_REQ: begin
          cyc_q <= 1'b1;
          adr_q <= ptbr_i + {{(AWID-11){1'b0}}, va_q[31:24], 3'b000};
          cnt_q <= '0;
          state <= ST_L1_WAIT;
        end
        ST_L1_WAIT: begin
          if (err_i) begin
            cyc_q   <= 1'b0;
            cause_q <= FC_BUS;
            state   <= ST_FAULT;
          end else if (ack_i) begin
            cyc_q <= 1'b0;
            if (!dat_i[PTE_V]) begin
              cause_q <= FC_ROOT;
              state   <= ST_FAULT;
            end else begin
              root_q <= dat_i[AWID-1:11];
              state  <= ST_L2_REQ;
            end
          end else if (cnt_q == TO_MAX) begin
            cyc_q   <= 1'b0;
            cause_q <= FC_BUS;
            state   <= ST_FAULT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_L2_REQ: begin
          cyc_q <= 1'b1;
          adr_q <= {root_q, 11'b0} + {{(AWID-13){1'b0}}, va_q[23:14], 3'b000};
          cnt_q <= '0;
          state <= ST_L2_WAIT;
        end
        ST_L2_WAIT: begin
          if (err_i) begin
            cyc_q   <= 1'b0;
            cause_q <= FC_BUS;
            state   <= ST_FAULT;
          end else if (ack_i) begin
            cyc_q <= 1'b0;
            if (!dat_i[PTE_V]) begin
              cause_q <= FC_LEAF;
              state   <= ST_FAULT;
            end else begin
              pte_q <= dat_i[31:0];
              state <= ST_WRITE;
            end
          end else if (cnt_q == TO_MAX) begin
            cyc_q   <= 1'b0;
            cause_q <= FC_BUS;
            state   <= ST_FAULT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WRITE: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        ST_FAULT: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign tlbe          = pte_to_tlbe(pte_q, va_q[31:24], asid_q);
  assign cyc_o         = cyc_q;
  assign stb_o         = cyc_q;
  assign adr_o         = adr_q;
  assign busy_o        = (state != ST_IDLE);
  assign done_o        = (state == ST_DONE);
  assign fault_o       = (state == ST_FAULT);
  assign fault_cause_o = cause_q;
  assign unused_bits   = ^{dat_i[63:32], miss_adr_i[13:0]};

  // TLB port arbitration: walker owns the port only in WRITE, software passes through otherwise.
  always_comb begin
    sw_busy_o = 1'b0;
    wrtlb_o   = sw_wr_i;
    tlbadr_o  = sw_adr_i;
    tlbdat_o  = sw_dat_i;
    if (state == ST_WRITE) begin
      wrtlb_o   = 1'b1;
      tlbadr_o  = {1'b1, 5'b0, va_q[23:14]};
      tlbdat_o  = tlbe;
      sw_busy_o = sw_wr_i;
    end
  end

endmodule
